regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: req0 = ALU/execute result, req1 = memory load result.
- Each requester has a valid/ready handshake and a one-entry holding buffer.
- Round-robin arbitration, with an age override so that same-register writes commit in acceptance order.
- Exposes read-hazard flags so decode can stall while a buffered write to a read register has not committed.

---
 rtl/regfile_wb_arbiter_pkg.sv | 34 +++
 rtl/regfile_wb_arbiter_if.sv | 47 ++++
 rtl/regfile_wb_arbiter_wb_slot.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, payload types and helpers for the regfile writeback arbiter.
//   DATA_W / ADDR_W : write data and register address widths
//   ZERO_REG        : hardwired-zero register (XZR); writes to it are discarded
//   wb_req_t        : {addr, data} request payload
//   wb_buf_t        : {full, addr, data} holding-buffer contents
package regfile_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_buf_t;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

  // A read of XZR never needs to wait on anything.
  function automatic logic pending_write(input wb_buf_t b0, input wb_buf_t b1,
                                         input logic [ADDR_W-1:0] ra);
    if (is_zero_reg(ra)) return 1'b0;
    return (b0.full && (b0.addr == ra)) || (b1.full && (b1.addr == ra));
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, decode read-hazard query and the
// regfile write port.
//   req0_* : execute result handshake (valid/ready/addr/data)
//   req1_* : load result handshake (valid/ready/addr/data)
//   we3/wa3/wd3 : regfile write port
//   ra1/ra2 -> hz1/hz2 : decode hazard query
//   idle : both holding buffers empty
// slave = arbiter side, master = requesters/decode/regfile side.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              hz1;
  logic              hz2;
  logic              idle;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  ra1, ra2,
    output req0_ready, req1_ready,
    output we3, wa3, wd3,
    output hz1, hz2, idle
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output ra1, ra2,
    input  req0_ready, req1_ready,
    input  we3, wa3, wd3,
    input  hz1, hz2, idle
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer.
//   clk, reset_n : clock, async active-low reset (empties the buffer)
//   load         : request accepted this cycle (valid && ready)
//   clear        : buffer is being committed this cycle
//   req          : incoming {addr, data}
//   slot         : registered {full, addr, data}
// A load wins over a clear (pass-through refill). A load to XZR is accepted
// but leaves the buffer empty.
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    load,
  input  logic    clear,
  input  wb_req_t req,
  output wb_buf_t slot
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
    end else if (load) begin
      slot.full <= !is_zero_reg(req.addr);
      slot.addr <= req.addr;
      slot.data <= req.data;
    end else if (clear) begin
      slot.full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between execute (req0) and load (req1)
// writebacks. Each requester owns a one-entry buffer; buffers are granted
// round-robin, except that two buffered writes to the same register commit
// in acceptance order.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : request handshakes, regfile write port, hazard query, idle
// Write-port and hazard outputs depend only on buffer registers and ra1/ra2,
// never on reqN_valid.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus
);

  wb_req_t req0, req1;
  wb_buf_t buf0, buf1;
  logic    grant0, grant1;
  logic    ready0, ready1;
  logic    load0, load1;
  logic    load0_eff, load1_eff;
  logic    keep0, keep1;
  logic    last_grant;   // 1: buf1 won the most recent grant
  logic    older;        // 1: buf1 holds the older entry (valid when both full)

  assign req0 = {bus.req0_addr, bus.req0_data};
  assign req1 = {bus.req1_addr, bus.req1_data};

  // Grant selection from buffer state only.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (buf0.full && buf1.full) begin
      if (buf0.addr == buf1.addr) begin
        grant1 = older;
        grant0 = !older;
      end else begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end
    end else begin
      grant0 = buf0.full;
      grant1 = buf1.full;
    end
  end

  // A buffer being committed can take a new request in the same cycle.
  assign ready0 = !buf0.full || grant0;
  assign ready1 = !buf1.full || grant1;
  assign load0  = bus.req0_valid && ready0;
  assign load1  = bus.req1_valid && ready1;

  assign load0_eff = load0 && !is_zero_reg(bus.req0_addr);
  assign load1_eff = load1 && !is_zero_reg(bus.req1_addr);
  assign keep0     = buf0.full && !grant0;
  assign keep1     = buf1.full && !grant1;

  wb_slot u_slot0 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load0),
    .clear   (grant0),
    .req     (req0),
    .slot    (buf0)
  );

  wb_slot u_slot1 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load1),
    .clear   (grant1),
    .req     (req1),
    .slot    (buf1)
  );

  // Round-robin pointer and relative age of the two buffered entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      older      <= 1'b0;
    end else begin
      if (grant0 || grant1) last_grant <= grant1;
      if (load0_eff && load1_eff)  older <= 1'b1;
      else if (load0_eff && keep1) older <= 1'b1;
      else if (load1_eff && keep0) older <= 1'b0;
    end
  end

  // Regfile write port; address and data are zero when nothing commits.
  always_comb begin
    bus.we3 = 1'b0;
    bus.wa3 = '0;
    bus.wd3 = '0;
    if (grant0) begin
      bus.we3 = 1'b1;
      bus.wa3 = buf0.addr;
      bus.wd3 = buf0.data;
    end else if (grant1) begin
      bus.we3 = 1'b1;
      bus.wa3 = buf1.addr;
      bus.wd3 = buf1.data;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.hz1        = pending_write(buf0, buf1, bus.ra1);
  assign bus.hz2        = pending_write(buf0, buf1, bus.ra2);
  assign bus.idle       = !buf0.full && !buf1.full;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a sequence-numbered reference model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending write per requester, tagged by acceptance order.
  logic              m_full [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_data [2];
  int                m_seq  [2];
  int                seq_ctr;
  logic              m_last;   // requester that won the latest grant

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return m_last ? 0 : 1;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_hz(input logic [ADDR_W-1:0] ra);
    if (ra == ADDR_W'(31)) return 1'b0;
    return (m_full[0] && m_addr[0] == ra) || (m_full[1] && m_addr[1] == ra);
  endfunction

  task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.ra1 = r1; bus.ra2 = r2;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.hz1, bus.hz2, bus.idle, bus.req0_ready, bus.req1_ready} !== 6'b000111) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000111",
               {bus.we3, bus.hz1, bus.hz2, bus.idle, bus.req0_ready, bus.req1_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3, bus.idle} !== {1'b0, 5'd0, 64'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release: we3=%b wa3=%0d wd3=%h idle=%b expected 0/0/0/1",
               bus.we3, bus.wa3, bus.wd3, bus.idle);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    drive(1'b1, 5'd5, 64'hAB, 1'b0, '0, '0, 5'd5, '0);
    #1;
    vectors++;
    if (bus.we3 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_comb_path: we3 got %b expected 0", bus.we3);
    end
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd5, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3, bus.hz1, bus.idle} !== {1'b1, 5'd5, 64'hAB, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_commit: we3=%b wa3=%0d wd3=%h hz1=%b idle=%b expected 1/5/ab/1/0",
               bus.we3, bus.wa3, bus.wd3, bus.hz1, bus.idle);
    end
    step();
    #1;
    vectors++;
    if ({bus.we3, bus.hz1, bus.idle} !== 3'b001) begin
      miscompares++;
      $display("FAIL single_drained: we3/hz1/idle got %b expected 001", {bus.we3, bus.hz1, bus.idle});
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, '0, '0);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL contention_accept: ready got %b expected 11", {bus.req0_ready, bus.req1_ready});
    end
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd8, 64'h88, '0, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3, bus.req0_ready, bus.req1_ready} !== {1'b1, 5'd3, 64'h33, 2'b10}) begin
      miscompares++;
      $display("FAIL contention_first: we3=%b wa3=%0d wd3=%h rdy=%b%b expected 1/3/33/10",
               bus.we3, bus.wa3, bus.wd3, bus.req0_ready, bus.req1_ready);
    end
    step();
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3, bus.req1_ready} !== {1'b1, 5'd4, 64'h44, 1'b1}) begin
      miscompares++;
      $display("FAIL contention_second: we3=%b wa3=%0d wd3=%h rdy1=%b expected 1/4/44/1",
               bus.we3, bus.wa3, bus.wd3, bus.req1_ready);
    end
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd8, 64'h88}) begin
      miscompares++;
      $display("FAIL contention_refill: we3=%b wa3=%0d wd3=%h expected 1/8/88",
               bus.we3, bus.wa3, bus.wd3);
    end
  endtask

  task automatic test_same_addr();
    // req1 refills behind a blocked buf0 holding the same register.
    do_reset();
    drive(1'b1, 5'd2, 64'h22, 1'b1, 5'd4, 64'h44, '0, '0);
    step();
    drive(1'b1, 5'd7, 64'h1, 1'b0, '0, '0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 64'h2, '0, '0);
    #1;
    vectors++;
    if ({bus.wa3, bus.req0_ready, bus.req1_ready} !== {5'd4, 2'b01}) begin
      miscompares++;
      $display("FAIL same_addr_block: wa3=%0d rdy=%b%b expected 4/01",
               bus.wa3, bus.req0_ready, bus.req1_ready);
    end
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd7, 64'h1}) begin
      miscompares++;
      $display("FAIL same_addr_first: we3=%b wa3=%0d wd3=%h expected 1/7/1", bus.we3, bus.wa3, bus.wd3);
    end
    step();
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd7, 64'h2}) begin
      miscompares++;
      $display("FAIL same_addr_last: we3=%b wa3=%0d wd3=%h expected 1/7/2", bus.we3, bus.wa3, bus.wd3);
    end
    // Both accepted on one edge: the load result (buf1) counts as older.
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 64'h55, '0, '0);
    step();
    drive(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd7, 64'h2}) begin
      miscompares++;
      $display("FAIL same_edge_older: we3=%b wa3=%0d wd3=%h expected 1/7/2", bus.we3, bus.wa3, bus.wd3);
    end
    step();
    #1;
    vectors++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd7, 64'h1}) begin
      miscompares++;
      $display("FAIL same_edge_newer: we3=%b wa3=%0d wd3=%h expected 1/7/1", bus.we3, bus.wa3, bus.wd3);
    end
  endtask

  task automatic test_xzr();
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 5'd31, 64'hFF, 5'd31, 5'd31);
    #1;
    vectors++;
    if (bus.req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL xzr_ready: got %b expected 1", bus.req1_ready);
    end
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd31, 5'd31);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.we3, bus.hz1, bus.hz2, bus.idle} !== 4'b0001) begin
        miscompares++;
        $display("FAIL xzr_discard[%0d]: we3/hz1/hz2/idle got %b expected 0001", i,
                 {bus.we3, bus.hz1, bus.hz2, bus.idle});
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] dat [10];
    do_reset();
    for (int i = 0; i < 10; i++) dat[i] = {$urandom, $urandom};
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, ADDR_W'(i), dat[i], 1'b0, '0, '0, '0, '0);
      else        drive(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
      #1;
      if (i < 10) begin
        vectors++;
        if (bus.req0_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.req0_ready);
        end
      end
      if (i >= 1) begin
        vectors++;
        if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, ADDR_W'(i - 1), dat[i-1]}) begin
          miscompares++;
          $display("FAIL stream_commit[%0d]: we3=%b wa3=%0d wd3=%h expected 1/%0d/%h",
                   i, bus.we3, bus.wa3, bus.wd3, i - 1, dat[i-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 5'd3, 5'd4);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd4);
    #1;
    vectors++;
    if ({bus.idle, bus.hz1, bus.hz2} !== 3'b011) begin
      miscompares++;
      $display("FAIL midreset_full: idle/hz1/hz2 got %b expected 011", {bus.idle, bus.hz1, bus.hz2});
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.we3, bus.idle, bus.hz1, bus.hz2, bus.req0_ready, bus.req1_ready} !== 6'b010011) begin
      miscompares++;
      $display("FAIL midreset_async: we3/idle/hz1/hz2/rdy got %b expected 010011",
               {bus.we3, bus.idle, bus.hz1, bus.hz2, bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.we3, bus.idle} !== 2'b01) begin
        miscompares++;
        $display("FAIL midreset_after[%0d]: we3/idle got %b expected 01", i, {bus.we3, bus.idle});
      end
      step();
    end
  endtask

  task automatic test_random();
    logic              v0, v1;
    logic [ADDR_W-1:0] a0, a1, r1, r2;
    logic [DATA_W-1:0] d0, d1;
    logic              acc0, acc1;
    int                g;
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_wd;
    do_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_addr[0] = '0;   m_addr[1] = '0;
    m_data[0] = '0;   m_data[1] = '0;
    m_seq[0]  = 0;    m_seq[1]  = 0;
    seq_ctr   = 0;
    m_last    = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // Small address pool (with XZR) to force same-register collisions.
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 6);
      a0 = (($urandom_range(0, 4) == 4) ? ADDR_W'(31) : ADDR_W'($urandom_range(0, 3)));
      a1 = (($urandom_range(0, 4) == 4) ? ADDR_W'(31) : ADDR_W'($urandom_range(0, 3)));
      r1 = (($urandom_range(0, 4) == 4) ? ADDR_W'(31) : ADDR_W'($urandom_range(0, 4)));
      r2 = (($urandom_range(0, 4) == 4) ? ADDR_W'(31) : ADDR_W'($urandom_range(0, 4)));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      drive(v0, a0, d0, v1, a1, d1, r1, r2);
      #1;
      g      = m_grant();
      exp_wa = (g >= 0) ? m_addr[g] : '0;
      exp_wd = (g >= 0) ? m_data[g] : '0;
      vectors++;
      if ({bus.we3, bus.wa3, bus.wd3} !== {(g >= 0), exp_wa, exp_wd}) begin
        miscompares++;
        $display("FAIL rand_commit[%0d]: we3=%b wa3=%0d wd3=%h expected %b/%0d/%h",
                 cyc, bus.we3, bus.wa3, bus.wd3, (g >= 0), exp_wa, exp_wd);
      end
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {(!m_full[0] || g == 0), (!m_full[1] || g == 1)}) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", cyc, bus.req0_ready, bus.req1_ready,
                 (!m_full[0] || g == 0), (!m_full[1] || g == 1));
      end
      vectors++;
      if ({bus.hz1, bus.hz2} !== {m_hz(r1), m_hz(r2)}) begin
        miscompares++;
        $display("FAIL rand_hazard[%0d]: got %b%b expected %b%b", cyc, bus.hz1, bus.hz2, m_hz(r1), m_hz(r2));
      end
      vectors++;
      if (bus.idle !== (!m_full[0] && !m_full[1])) begin
        miscompares++;
        $display("FAIL rand_idle[%0d]: got %b expected %b", cyc, bus.idle, (!m_full[0] && !m_full[1]));
      end
      // Advance the model across the coming clock edge.
      acc0 = v0 && (!m_full[0] || g == 0);
      acc1 = v1 && (!m_full[1] || g == 1);
      if (g >= 0) begin
        m_full[g] = 1'b0;
        m_last    = (g == 1);
      end
      if (acc1 && a1 != ADDR_W'(31)) begin
        m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_seq[1] = seq_ctr; seq_ctr++;
      end
      if (acc0 && a0 != ADDR_W'(31)) begin
        m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_seq[0] = seq_ctr; seq_ctr++;
      end
      step();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_xzr();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
